hazard_controller: RTL and testbench

- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives enable/clear of the F/D, D/E, E/M and M/W pipeline registers and the E-stage forwarding muxes.
- Resolves RAW forwarding, load-use stalls and taken-branch/jump flushes.
- Freezes the pipeline while a variable-latency data-memory access completes, with timeout detection and saturating performance counters.

---
 rtl/hazard_controller.sv | 176 +++++++++++++++++
 tb/tb_hazard_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for a 5-stage pipeline: forwarding, load-use stalls,
// branch flushes, and a memory-wait FSM with timeout and saturating performance counters.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic             mem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_req,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [7:0] TIMEOUT_W = MEM_TIMEOUT[7:0];

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        ERROR = 2'b10
    } mem_state_t;

    mem_state_t       state_reg, state_next;
    logic [7:0]       wait_cnt_reg, wait_cnt_next;
    logic             err_reg;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    logic             acc;
    logic             mem_stall;
    logic             mem_req_int;
    logic             lu;
    logic             flush_event;

    logic [4:0]       rs_e [2];
    logic [1:0]       fwd  [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    // M-stage result is younger than W, so it wins when both match.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd[gi] = 2'b00;
                if (RegWriteM && (RdM != 5'd0) && (RdM == rs_e[gi]))
                    fwd[gi] = 2'b10;
                else if (RegWriteW && (RdW != 5'd0) && (RdW == rs_e[gi]))
                    fwd[gi] = 2'b01;
            end
        end
    endgenerate

    assign acc = MemReadM | MemWriteM;
    assign lu  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_stall     = 1'b0;
        mem_req_int   = 1'b0;
        case (state_reg)
            IDLE: begin
                mem_req_int = acc;
                if (acc && !mem_ready) begin
                    mem_stall     = 1'b1;
                    state_next    = WAIT;
                    wait_cnt_next = 8'd1;
                end
            end
            WAIT: begin
                mem_req_int = 1'b1;
                if (mem_ready) begin
                    state_next    = IDLE;
                    wait_cnt_next = 8'd0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_reg == TIMEOUT_W)
                        state_next = ERROR;
                    else
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            ERROR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are gated by rst_n so they drop the moment reset asserts, without a clock edge.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        mem_req   = 1'b0;
        if (rst_n) begin
            ForwardAE = fwd[0];
            ForwardBE = fwd[1];
            mem_req   = mem_req_int;
            if (mem_stall) begin
                // E is frozen, so a pending branch or load-use is simply retried on release.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lu) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign flush_event = PCSrcE && !mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= 8'd0;
            err_reg       <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_next == ERROR)
                err_reg <= 1'b1;
            if (StallF && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (flush_event && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign mem_timeout_err = err_reg;
    assign stall_count     = stall_cnt_reg;
    assign flush_count     = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, memory wait, branch deferral,
// async reset and memory timeout, checked with immediate assertions.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, MemReadM, MemWriteM, mem_ready;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        mem_req, mem_timeout_err;
    logic [31:0] stall_count, flush_count;

    int vectors    = 0;
    int miscompares = 0;

    hazard_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .mem_ready(mem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_req(mem_req), .mem_timeout_err(mem_timeout_err),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0;
        MemReadM = 0; MemWriteM = 0; mem_ready = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Hazard-provoking inputs while reset is held: every output must stay quiet.
        RegWriteM = 1; RdM = 5; Rs1E = 5; MemReadM = 1; PCSrcE = 1;
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #3;
        chk("rst_fwdA", {30'd0, ForwardAE}, 32'd0);
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_flushD", {31'd0, FlushD}, 32'd0);
        chk("rst_stallF", {31'd0, StallF}, 32'd0);
        chk("rst_stallcnt", stall_count, 32'd0);
        chk("rst_err", {31'd0, mem_timeout_err}, 32'd0);
        #9;
        clear_inputs();
        rst_n = 1'b1;
        cyc();

        // Forwarding
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
        #1;
        chk("fwd_M_wins", {30'd0, ForwardAE}, 32'd2);
        chk("fwd_x0_B", {30'd0, ForwardBE}, 32'd0);
        RdM = 0;
        #1;
        chk("fwd_W_when_RdM0", {30'd0, ForwardAE}, 32'd1);
        RdM = 5; RegWriteM = 0; Rs2E = 5;
        #1;
        chk("fwd_B_W", {30'd0, ForwardBE}, 32'd1);
        RdW = 0;
        #1;
        chk("fwd_none_RdW0", {30'd0, ForwardBE}, 32'd0);
        chk("fwd_no_stall", {31'd0, StallF}, 32'd0);
        cyc();
        clear_inputs();

        // Load-use: RdE=0 must not stall, then a real hazard for one cycle
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        #1;
        chk("lu_x0_none", {31'd0, StallF}, 32'd0);
        RdE = 7; Rs2D = 7; Rs1D = 3;
        #1;
        chk("lu_stallF", {31'd0, StallF}, 32'd1);
        chk("lu_stallD", {31'd0, StallD}, 32'd1);
        chk("lu_flushE", {31'd0, FlushE}, 32'd1);
        chk("lu_stallE", {31'd0, StallE}, 32'd0);
        cyc();
        clear_inputs();
        #1;
        chk("lu_one_cycle", {31'd0, StallF}, 32'd0);
        chk("lu_stallcnt", stall_count, 32'd1);

        // Zero-wait access
        MemWriteM = 1; mem_ready = 1;
        #1;
        chk("zw_memreq", {31'd0, mem_req}, 32'd1);
        chk("zw_nostall", {31'd0, StallF}, 32'd0);
        cyc();
        clear_inputs();

        // Three-cycle wait then ready
        MemReadM = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_memreq", {31'd0, mem_req}, 32'd1);
            chk("mw_stallF", {31'd0, StallF}, 32'd1);
            chk("mw_stallM", {31'd0, StallM}, 32'd1);
            chk("mw_flushW", {31'd0, FlushW}, 32'd1);
            cyc();
        end
        mem_ready = 1;
        #1;
        chk("mw_rel_memreq", {31'd0, mem_req}, 32'd1);
        chk("mw_rel_stallF", {31'd0, StallF}, 32'd0);
        chk("mw_rel_flushW", {31'd0, FlushW}, 32'd0);
        cyc();
        clear_inputs();
        #1;
        chk("mw_idle_memreq", {31'd0, mem_req}, 32'd0);
        chk("mw_stallcnt", stall_count, 32'd4);

        // Branch held during a 2-cycle wait, flushed on release
        MemReadM = 1; mem_ready = 0; PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("br_wait_flushD", {31'd0, FlushD}, 32'd0);
            chk("br_wait_flushE", {31'd0, FlushE}, 32'd0);
            chk("br_wait_stallF", {31'd0, StallF}, 32'd1);
            cyc();
        end
        mem_ready = 1;
        #1;
        chk("br_rel_flushD", {31'd0, FlushD}, 32'd1);
        chk("br_rel_flushE", {31'd0, FlushE}, 32'd1);
        chk("br_rel_stallF", {31'd0, StallF}, 32'd0);
        cyc();
        clear_inputs();
        #1;
        chk("br_flushcnt", flush_count, 32'd1);
        chk("br_stallcnt", stall_count, 32'd6);

        // Branch beats a simultaneous load-use
        PCSrcE = 1; ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #1;
        chk("brlu_flushD", {31'd0, FlushD}, 32'd1);
        chk("brlu_stallF", {31'd0, StallF}, 32'd0);
        cyc();
        clear_inputs();
        #1;
        chk("brlu_flushcnt", flush_count, 32'd2);
        chk("brlu_stallcnt", stall_count, 32'd6);

        // Asynchronous reset in the middle of a wait
        MemReadM = 1; mem_ready = 0;
        cyc();
        chk("rw_wait_memreq", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_async_memreq", {31'd0, mem_req}, 32'd0);
        chk("rw_async_stallF", {31'd0, StallF}, 32'd0);
        chk("rw_async_stallcnt", stall_count, 32'd0);
        chk("rw_async_flushcnt", flush_count, 32'd0);
        clear_inputs();
        rst_n = 1'b1;
        cyc();
        chk("rw_idle_memreq", {31'd0, mem_req}, 32'd0);
        chk("rw_idle_stallcnt", stall_count, 32'd0);
        MemReadM = 1; mem_ready = 1;
        #1;
        chk("rw_idle_zerowait", {31'd0, StallF}, 32'd0);
        cyc();
        clear_inputs();

        // Timeout: one IDLE stall cycle, 16 WAIT cycles, then ERROR
        MemWriteM = 1; mem_ready = 0;
        #1;
        chk("to_idle_stall", {31'd0, StallF}, 32'd1);
        cyc();
        for (int i = 1; i <= 16; i++) begin
            chk("to_wait_memreq", {31'd0, mem_req}, 32'd1);
            chk("to_wait_err", {31'd0, mem_timeout_err}, 32'd0);
            cyc();
        end
        chk("to_err_flag", {31'd0, mem_timeout_err}, 32'd1);
        chk("to_err_memreq", {31'd0, mem_req}, 32'd0);
        chk("to_err_stallF", {31'd0, StallF}, 32'd1);
        chk("to_err_stallcnt", stall_count, 32'd17);
        MemWriteM = 0; mem_ready = 1;
        cyc();
        chk("to_err_hold_stallE", {31'd0, StallE}, 32'd1);
        chk("to_err_hold_flag", {31'd0, mem_timeout_err}, 32'd1);
        chk("to_err_hold_cnt", stall_count, 32'd18);
        rst_n = 1'b0;
        #1;
        chk("to_rst_err", {31'd0, mem_timeout_err}, 32'd0);
        chk("to_rst_stallF", {31'd0, StallF}, 32'd0);
        rst_n = 1'b1;
        clear_inputs();
        cyc();
        chk("to_after_stallF", {31'd0, StallF}, 32'd0);
        chk("to_after_cnt", stall_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
